// File: rtl/fetch_ir_unit_pkg.sv
// fetch_ir_unit_pkg: opcode, immediate-source, fault-cause and NOP constants shared by fetch and decode
package fetch_ir_unit_pkg;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [2:0] IMMSRC_ITYPE = 3'd0;
  localparam logic [2:0] IMMSRC_STYPE = 3'd1;
  localparam logic [2:0] IMMSRC_BTYPE = 3'd2;
  localparam logic [2:0] IMMSRC_JTYPE = 3'd3;
  localparam logic [2:0] IMMSRC_UTYPE = 3'd4;
  localparam logic [1:0] FCAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] FCAUSE_ACCESS   = 2'd1;
  localparam logic [1:0] FCAUSE_TIMEOUT  = 2'd2;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_ir_unit_if.sv
// fetch_ir_unit_if: instruction memory read port between the fetch unit and the memory/MMU
interface fetch_ir_unit_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_fault;
  modport master (output mem_valid, mem_addr, input mem_ready, mem_rdata, mem_fault);
  modport slave (input mem_valid, mem_addr, output mem_ready, mem_rdata, mem_fault);
endinterface

// File: rtl/fetch_ir_unit_immsrc_predecode.sv
// immsrc_predecode: maps a 7-bit opcode to its immediate format; unknown opcodes fall back to I-type
module immsrc_predecode
  import fetch_ir_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] immsrc
);
  assign immsrc = opcode == OPC_STORE  ? IMMSRC_STYPE :
                  opcode == OPC_BRANCH ? IMMSRC_BTYPE :
                  opcode == OPC_JAL    ? IMMSRC_JTYPE :
                  (opcode == OPC_LUI || opcode == OPC_AUIPC) ? IMMSRC_UTYPE :
                  IMMSRC_ITYPE;
endmodule

// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit: issues one instruction read per fetch request and latches instr, its PC and immsrc
module fetch_ir_unit
  import fetch_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter int          TMO_W          = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            fetch_start,
  input  logic [31:0]     pc_in,
  input  logic            flush,
  fetch_ir_unit_if.master bus,
  output logic [31:0]     instr,
  output logic [31:0]     old_pc,
  output logic [2:0]      immsrc,
  output logic            busy,
  output logic            fetch_done,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam bit TMO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic drop_q, drop_d, ir_we, done_d, fault_d;
  logic [1:0] cause_d;
  logic [2:0] pre_imm;
  immsrc_predecode u_predecode (.opcode(bus.mem_rdata[6:0]), .immsrc(pre_imm));
  assign bus.mem_valid = state_q == S_WAIT;
  assign bus.mem_addr  = addr_q;
  assign busy          = state_q == S_WAIT;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    ir_we   = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    cause_d = fault_cause;
    if (state_q == S_IDLE) begin
      drop_d = 1'b0;
      tmo_d  = '0;
      if (fetch_start) begin
        fault_d = |pc_in[1:0];
        cause_d = fault_d ? FCAUSE_MISALIGN : fault_cause;
        state_d = fault_d ? S_IDLE : S_WAIT;
        addr_d  = fault_d ? addr_q : pc_in;
      end
    end else begin
      // a flush coinciding with mem_ready still drops the response
      drop_d = drop_q | flush;
      if (bus.mem_ready) begin
        state_d = S_IDLE;
        ir_we   = !drop_d && !bus.mem_fault;
        done_d  = ir_we;
        fault_d = !drop_d && bus.mem_fault;
        cause_d = fault_d ? FCAUSE_ACCESS : fault_cause;
      end else if (TMO_EN && tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        fault_d = !drop_d;
        cause_d = fault_d ? FCAUSE_TIMEOUT : fault_cause;
      end else begin
        tmo_d = TMO_EN ? tmo_q + 1'b1 : tmo_q;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      tmo_q       <= '0;
      drop_q      <= 1'b0;
      instr       <= INSTR_NOP;
      old_pc      <= RESET_VECTOR;
      immsrc      <= IMMSRC_ITYPE;
      fetch_done  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= FCAUSE_MISALIGN;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      fetch_done  <= done_d;
      fetch_fault <= fault_d;
      fault_cause <= cause_d;
      if (ir_we) begin
        instr  <= bus.mem_rdata;
        old_pc <= addr_q;
        immsrc <= pre_imm;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb_fetch_ir_unit: directed vector table plus randomized transactions against a transaction-level model
module tb_fetch_ir_unit;
  import fetch_ir_unit_pkg::*;
  localparam logic [31:0] RV = 32'h1000_0000;
  localparam int TMO = 8;
  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] rdata;
    logic        flt;
    int          fl;
    int          kind;
    int          cyc;
    int          nv;
    logic [31:0] instr;
    logic [31:0] opc;
    logic [2:0]  imm;
    logic [1:0]  cause;
  } vec_t;
  logic clk = 1'b0;
  logic resetn, fetch_start, flush, busy, fetch_done, fetch_fault;
  logic [31:0] pc_in, instr, old_pc;
  logic [2:0] immsrc;
  logic [1:0] fault_cause;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_instr, m_pc;
  logic [2:0] m_imm;
  logic [1:0] m_cause;
  vec_t tab [11];
  fetch_ir_unit_if bus ();
  fetch_ir_unit #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TMO), .TMO_W(16)) dut (
    .clk(clk), .resetn(resetn), .fetch_start(fetch_start), .pc_in(pc_in), .flush(flush),
    .bus(bus), .instr(instr), .old_pc(old_pc), .immsrc(immsrc), .busy(busy),
    .fetch_done(fetch_done), .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h23:        return IMMSRC_STYPE;
      7'h63:        return IMMSRC_BTYPE;
      7'h6F:        return IMMSRC_JTYPE;
      7'h37, 7'h17: return IMMSRC_UTYPE;
      default:      return IMMSRC_ITYPE;
    endcase
  endfunction
  task automatic predict(input vec_t v, output vec_t r);
    int last;
    bit dropped;
    r = v;
    r.cyc = 0;
    if (v.pc[1:0] != 2'b00) begin
      r.kind = 2; r.cyc = 1; r.nv = 0; m_cause = FCAUSE_MISALIGN;
    end else begin
      last = v.lat < TMO ? v.lat : TMO - 1;
      r.nv = last + 1;
      dropped = v.fl >= 0 && v.fl <= last;
      r.kind = dropped ? 0 : (v.lat >= TMO || v.flt) ? 2 : 1;
      if (r.kind != 0) r.cyc = last + 2;
      if (r.kind == 2) m_cause = v.lat >= TMO ? FCAUSE_TIMEOUT : FCAUSE_ACCESS;
      if (r.kind == 1) begin
        m_instr = v.rdata; m_pc = v.pc; m_imm = imm_of(v.rdata[6:0]);
      end
    end
    r.instr = m_instr; r.opc = m_pc; r.imm = m_imm; r.cause = m_cause;
  endtask
  task automatic apply(input int id, input vec_t v);
    int nv, np, pk, pcyc;
    bit both, addr_bad;
    nv = 0; np = 0; pk = 0; pcyc = 0; both = 0; addr_bad = 0;
    @(negedge clk);
    fetch_start = 1'b1; pc_in = v.pc; bus.mem_ready = 1'b0; flush = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      fetch_start = 1'b0;
      if (fetch_done || fetch_fault) begin
        np++; pk = fetch_done ? 1 : 2; pcyc = k;
        if (fetch_done && fetch_fault) both = 1'b1;
      end
      if (bus.mem_valid) begin
        if (bus.mem_addr !== v.pc) addr_bad = 1'b1;
        bus.mem_ready = nv == v.lat; bus.mem_fault = v.flt; bus.mem_rdata = v.rdata; flush = nv == v.fl;
        nv++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1)); bus.mem_fault = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom; flush = 1'($urandom_range(0, 1));
      end
    end
    bus.mem_ready = 1'b0; flush = 1'b0;
    chk($sformatf("v%0d kind", id), pk, v.kind);
    chk($sformatf("v%0d pulses", id), np, (v.kind != 0) ? 1 : 0);
    if (v.kind != 0) chk($sformatf("v%0d pulse_cycle", id), pcyc, v.cyc);
    chk($sformatf("v%0d valid_cycles", id), nv, v.nv);
    chk($sformatf("v%0d done_and_fault", id), both, 0);
    chk($sformatf("v%0d addr_unstable", id), addr_bad, 0);
    chk($sformatf("v%0d instr", id), instr, v.instr);
    chk($sformatf("v%0d old_pc", id), old_pc, v.opc);
    chk($sformatf("v%0d immsrc", id), immsrc, v.imm);
    chk($sformatf("v%0d fault_cause", id), fault_cause, v.cause);
    chk($sformatf("v%0d busy_end", id), busy, 0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, " mem_valid"}, bus.mem_valid, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " instr"}, instr, INSTR_NOP);
    chk({tag, " old_pc"}, old_pc, RV);
    chk({tag, " immsrc"}, immsrc, IMMSRC_ITYPE);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " pulses"}, {fetch_done, fetch_fault}, 0);
    chk({tag, " fault_cause"}, fault_cause, 0);
  endtask
  initial begin
    vec_t v, r;
    logic [6:0] opcs [14];
    opcs = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h13, 7'h33, 7'h2F, 7'h73, 7'h0F, 7'h7F, 7'h00};
    tab[0]  = '{32'h8000_0002, 0,  32'h0,         1'b0, -1, 2, 1, 0, 32'h0000_0013, RV,            IMMSRC_ITYPE, 2'd0};
    tab[1]  = '{32'h8000_0000, 3,  32'h0000_0463, 1'b0, -1, 1, 5, 4, 32'h0000_0463, 32'h8000_0000, IMMSRC_BTYPE, 2'd0};
    tab[2]  = '{32'h8000_0100, 1,  32'hDEAD_BEEF, 1'b1, -1, 2, 3, 2, 32'h0000_0463, 32'h8000_0000, IMMSRC_BTYPE, 2'd1};
    tab[3]  = '{32'h8000_0200, 5,  32'h0000_006F, 1'b0, 1,  0, 0, 6, 32'h0000_0463, 32'h8000_0000, IMMSRC_BTYPE, 2'd1};
    tab[4]  = '{32'h8000_0204, 0,  32'h0010_0093, 1'b0, -1, 1, 2, 1, 32'h0010_0093, 32'h8000_0204, IMMSRC_ITYPE, 2'd1};
    tab[5]  = '{32'h8000_0300, 99, 32'h0,         1'b0, -1, 2, 9, 8, 32'h0010_0093, 32'h8000_0204, IMMSRC_ITYPE, 2'd2};
    tab[6]  = '{32'h8000_0400, 7,  32'h0000_006F, 1'b0, -1, 1, 9, 8, 32'h0000_006F, 32'h8000_0400, IMMSRC_JTYPE, 2'd2};
    tab[7]  = '{32'h8000_0500, 2,  32'h0011_2023, 1'b0, -1, 1, 4, 3, 32'h0011_2023, 32'h8000_0500, IMMSRC_STYPE, 2'd2};
    tab[8]  = '{32'h8000_0504, 1,  32'h1234_5037, 1'b0, 1,  0, 0, 2, 32'h0011_2023, 32'h8000_0500, IMMSRC_STYPE, 2'd2};
    tab[9]  = '{32'h8000_0508, 1,  32'h1234_5037, 1'b0, -1, 1, 3, 2, 32'h1234_5037, 32'h8000_0508, IMMSRC_UTYPE, 2'd2};
    tab[10] = '{32'h8000_050C, 8,  32'h0,         1'b0, 7,  0, 0, 8, 32'h1234_5037, 32'h8000_0508, IMMSRC_UTYPE, 2'd2};
    resetn = 1'b0; fetch_start = 1'b0; pc_in = '0; flush = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.mem_fault = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    resetn = 1'b1;
    for (int i = 0; i < 11; i++) apply(i, tab[i]);
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0063;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready pulses", {fetch_done, fetch_fault}, 0);
    chk("late_ready instr", instr, 32'h1234_5037);
    chk("late_ready valid", bus.mem_valid, 0);
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 32'h8000_0600;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("midwait busy", busy, 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset_state("midwait_reset");
    @(negedge clk);
    resetn = 1'b1;
    m_instr = INSTR_NOP; m_pc = RV; m_imm = IMMSRC_ITYPE; m_cause = FCAUSE_MISALIGN;
    for (int i = 0; i < 80; i++) begin
      v.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      v.lat   = $urandom_range(0, 11);
      v.rdata = {25'($urandom), opcs[$urandom_range(0, 13)]};
      v.flt   = $urandom_range(0, 4) == 0;
      v.fl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      v.kind = 0; v.cyc = 0; v.nv = 0; v.instr = '0; v.opc = '0; v.imm = '0; v.cause = '0;
      predict(v, r);
      apply(100 + i, r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
- Instruction-fetch and instruction-register stage of the multicycle RV32IMA core.
- Issues one memory read per fetch request from the control FSM and latches the returned word into the IR, together with the PC it came from.
- Pre-decodes the opcode into an immediate-source code, registered alongside the IR.
- Feeds the immediate-extension stage (`instr[31:7]`, `immsrc`) and the main decoder directly.

Parameters:
- RESET_VECTOR, 32'h0000_0000: reset value of `old_pc`.
- TIMEOUT_CYCLES, 0: cycles to wait for `mem_ready` before raising a bus timeout fault. 0 disables the timeout.
- TMO_W, 16: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- fetch_start  in  1  one-cycle request from the control FSM to fetch at `pc_in`.
- pc_in  in  32  fetch address.
- flush  in  1  discard the in-flight fetch (trap or interrupt taken).
- mem_valid  out  1  read request to the instruction memory/MMU port.
- mem_addr  out  32  word address of the request.
- mem_ready  in  1  read data valid / transfer complete.
- mem_rdata  in  32  read data.
- mem_fault  in  1  access/page fault; qualified by `mem_ready`.
- instr  out  32  instruction register.
- old_pc  out  32  PC of the instruction held in `instr`.
- immsrc  out  3  pre-decoded immediate type for `instr`, using the IMMSRC encodings.
- busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse: `instr`, `old_pc` and `immsrc` updated.
- fetch_fault  out  1  one-cycle pulse: fetch failed.
- fault_cause  out  2  cause of the fault: 0 misaligned, 1 access/page fault, 2 timeout. Held until the next fault.

Behaviour:
- Reset values (asynchronous, `resetn`=0):
  - State IDLE; `mem_valid`=0; `mem_addr`=0.
  - `instr`=32'h0000_0013 (NOP); `old_pc`=RESET_VECTOR; `immsrc`=IMMSRC_ITYPE.
  - `busy`=0, `fetch_done`=0, `fetch_fault`=0, `fault_cause`=0.
  - Drop flag and timeout counter cleared.
- IDLE state:
  - On `fetch_start`, if `pc_in[1:0]`≠0: no bus request. Next cycle `fetch_fault`=1 with `fault_cause`=0. Stay in IDLE.
  - On `fetch_start` with an aligned PC: register `mem_addr`=`pc_in`, go to WAIT. `mem_valid`=1 and `busy`=1 from the next cycle.
- WAIT state:
  - `mem_valid` and `mem_addr` are held stable until `mem_ready`.
  - On `mem_ready` with `mem_fault`=0 and drop flag clear: `instr`=`mem_rdata`, `old_pc`=`mem_addr`, `immsrc`=predecode(`mem_rdata[6:0]`). `fetch_done`=1 next cycle; return to IDLE.
  - On `mem_ready` with `mem_fault`=1 and drop flag clear: IR, `old_pc` and `immsrc` unchanged. `fetch_fault`=1 with `fault_cause`=1; return to IDLE.
  - `mem_valid` deasserts in the cycle after `mem_ready`. Total latency from `fetch_start` to `fetch_done` is N+2 cycles when `mem_ready` arrives N cycles after `mem_valid` rises (N≥0).
- Flush:
  - `flush` in WAIT sets the drop flag. The bus transaction is never abandoned: `mem_valid` stays high until `mem_ready`.
  - The returned data or fault is discarded: no `fetch_done`, no `fetch_fault`. Return to IDLE.
  - `flush` in IDLE has no effect.
  - `flush` and `mem_ready` in the same cycle: data is dropped.
- Timeout (only when TIMEOUT_CYCLES>0):
  - The counter increments each WAIT cycle without `mem_ready`.
  - On reaching TIMEOUT_CYCLES: deassert `mem_valid`, pulse `fetch_fault` with `fault_cause`=2 (suppressed if the drop flag is set), return to IDLE.
  - A late `mem_ready` arriving in IDLE is ignored.
- `fetch_start` while `busy`=1 is ignored. The control FSM must not issue it.
- `fetch_done` and `fetch_fault` are mutually exclusive and never asserted in the same cycle.
- Predecode of the opcode:
  - LOAD, OP-IMM, JALR, SYSTEM, MISC-MEM map to I-type.
  - STORE maps to S-type; BRANCH to B-type; JAL to J-type; LUI and AUIPC to U-type.
  - OP, AMO and any unknown opcode map to I-type; the decoder flags illegal instructions.
- `instr` changes only on a successful fetch. It is stable during execute cycles and can feed extension logic combinationally.

Decomposition:
- Add to `riscv_defines.svh`:
  - Opcode constants: OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_AMO, OPC_SYSTEM, OPC_MISC_MEM.
  - Fault-cause constants: FCAUSE_MISALIGN, FCAUSE_ACCESS, FCAUSE_TIMEOUT.
  - NOP constant: INSTR_NOP.
  - Reuse the existing IMMSRC_* codes.
- Sub-module `immsrc_predecode`: purely combinational, 7-bit opcode to 3-bit immsrc. The main decoder reuses it.
- FSM state type is local (IDLE, WAIT).

Test Plan:
- Reset, then `fetch_start` with `pc_in`=0x8000_0000 and `mem_ready` 3 cycles after `mem_valid` returning 0x0000_0463 (BEQ) → `instr`=0x0000_0463, `old_pc`=0x8000_0000, `immsrc`=IMMSRC_BTYPE, `fetch_done` 5 cycles after `fetch_start`.
- `pc_in`=0x8000_0002 → no `mem_valid`; `fetch_fault`=1 next cycle, `fault_cause`=0; IR still NOP.
- `mem_ready` and `mem_fault` together at 0x8000_0100 → `fetch_fault`, `fault_cause`=1; `instr` and `old_pc` unchanged.
- `flush` one cycle after `mem_valid`, `mem_ready` 4 cycles later with 0x0000_006F → `mem_valid` held until ready; no pulse of either kind; IR unchanged; next fetch of 0x0010_0093 succeeds with `immsrc`=IMMSRC_ITYPE.
- TIMEOUT_CYCLES=8 and `mem_ready` never asserted → `mem_valid` drops after 8 WAIT cycles, `fault_cause`=2; a late `mem_ready` is ignored.
- `resetn` low mid-WAIT → all outputs take reset values immediately; `mem_valid`=0.
